// File: rtl/ysyx_24100027_ifu.sv
// Instruction fetch unit: owns the PC and fetches one instruction at a time over a valid/ready
// request and valid response bus. The fetched instruction is held stable while the core executes.
module ysyx_24100027_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp_err,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        exec_done,
  input  logic [31:0] npc,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {StBoot, StReq, StResp, StExec, StFault} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [1:0]  r_fault_cause;
  logic [31:0] r_instret;

  state_e      w_state_d;
  logic [31:0] w_pc_d;
  logic [31:0] w_inst_d;
  logic [1:0]  w_fault_cause_d;
  logic [31:0] w_instret_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= StBoot;
      r_pc          <= RESET_PC;
      r_inst        <= NOP_INST;
      r_fault_cause <= 2'd0;
      r_instret     <= 32'd0;
    end else begin
      r_state       <= w_state_d;
      r_pc          <= w_pc_d;
      r_inst        <= w_inst_d;
      r_fault_cause <= w_fault_cause_d;
      r_instret     <= w_instret_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_pc_d          = r_pc;
    w_inst_d        = r_inst;
    w_fault_cause_d = r_fault_cause;
    w_instret_d     = r_instret;
    case (r_state)
      StBoot: w_state_d = StReq;
      StReq: begin
        if (mem_req_ready) w_state_d = StResp;
      end
      StResp: begin
        if (mem_resp_valid) begin
          if (mem_resp_err) begin
            w_state_d       = StFault;
            w_fault_cause_d = 2'd1;
          end else begin
            w_state_d = StExec;
            w_inst_d  = mem_rdata;
          end
        end
      end
      StExec: begin
        if (exec_done) begin
          // A misaligned npc still retires the instruction that produced it.
          w_instret_d = r_instret + 32'd1;
          if (npc[1:0] == 2'b00) begin
            w_state_d = StReq;
            w_pc_d    = npc;
            w_inst_d  = NOP_INST;
          end else begin
            w_state_d       = StFault;
            w_fault_cause_d = 2'd2;
          end
        end
      end
      StFault: w_state_d = StFault;
      default: w_state_d = StBoot;
    endcase
  end

  assign mem_req_valid = (r_state == StReq);
  assign inst_valid    = (r_state == StExec);
  assign fault         = (r_state == StFault);
  assign mem_addr      = r_pc;
  assign pc            = r_pc;
  assign inst          = r_inst;
  assign fault_cause   = r_fault_cause;
  assign instret       = r_instret;

endmodule

// File: doc/ysyx_24100027_ifu.md
# ysyx_24100027_ifu

Instruction fetch unit for the single-cycle RV32 core. Owns the architectural PC register and fetches each instruction from instruction memory over a valid/ready request plus valid response interface. Presents a stable `pc`/`inst` pair to the execute core and captures the core's combinational `npc` on completion. Detects misaligned next-PC and bus errors, and counts retired instructions.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC value loaded on reset.
- `NOP_INST`, default 32'h0000_0013: `inst` value whenever no fetched instruction is held.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset. Asserting it (low) resets immediately; release is synchronous to `clk`.
- `mem_req_valid`  out  1: fetch request valid.
- `mem_req_ready`  in  1: memory accepts the request this cycle.
- `mem_addr`  out  32: fetch address; always equals `pc`.
- `mem_resp_valid`  in  1: response data valid.
- `mem_rdata`  in  32: fetched instruction word.
- `mem_resp_err`  in  1: bus error; qualified by `mem_resp_valid`.
- `pc`  out  32: current PC, fed to the core.
- `inst`  out  32: held instruction, fed to the core.
- `inst_valid`  out  1: `pc`/`inst` are valid for execution.
- `exec_done`  in  1: core has finished the instruction this cycle; `npc` is valid.
- `npc`  in  32: next PC from the core.
- `fault`  out  1: sticky fault flag.
- `fault_cause`  out  2: 0 none, 1 bus error, 2 misaligned PC.
- `instret`  out  32: retired-instruction count.

## Operation
- **States**:
  - `BOOT`: one cycle, then go to `REQ`.
  - `REQ`: `mem_req_valid`=1.
    - `mem_req_ready`=1 → go to `RESP`.
  - `RESP`: wait for a response.
    - `mem_resp_valid`=1 and `mem_resp_err`=0 → load `inst` from `mem_rdata`, go to `EXEC`.
    - `mem_resp_valid`=1 and `mem_resp_err`=1 → go to `FAULT` with cause 1.
  - `EXEC`: `inst_valid`=1.
    - `exec_done`=1 and `npc[1:0]`==0 → `pc`←`npc`, `instret`+1, `inst`←`NOP_INST`, go to `REQ`.
    - `exec_done`=1 and `npc[1:0]`!=0 → `instret`+1, `pc` unchanged, go to `FAULT` with cause 2.
  - `FAULT`: `fault`=1. No requests are issued and `inst_valid`=0. Only reset exits this state.
- **Ignored inputs**: `mem_resp_valid` outside `RESP` is ignored and consumes no data. `exec_done` outside `EXEC` is ignored.
- **Misalignment** is checked on `npc` only. `RESET_PC` is required to be word-aligned.
- **`instret`** wraps from 32'hFFFF_FFFF to 0 without flagging.
- **`fault_cause`** is written once on entry to `FAULT` and holds until reset.
- **Reset mid-operation** (in any state): return immediately to reset values. An outstanding memory response is dropped; the memory side must tolerate an abandoned request.

## Timing
- **Reset values**:
  - state `BOOT`
  - `pc`=`RESET_PC`, `inst`=`NOP_INST`
  - `inst_valid`=0, `mem_req_valid`=0
  - `fault`=0, `fault_cause`=0, `instret`=0
- **Decode**: `mem_req_valid`, `inst_valid` and `fault` decode directly from registered state, with no combinational input paths. `mem_addr`=`pc`.
- **Request stability**: while `mem_req_valid`=1 and `mem_req_ready`=0, `mem_addr` is held stable.
- **Response timing**: the response is expected no earlier than the cycle after request acceptance. A response in the acceptance cycle is ignored.
- **Minimum throughput** (ready and response each in a single cycle, `exec_done` in the first `EXEC` cycle): 3 cycles per instruction (`REQ`, `RESP`, `EXEC`). The first `mem_req_valid` is seen in cycle 2 after reset release.
- **Same-cycle commit**: `exec_done` may arrive in the same cycle `inst_valid` first rises. `pc` updates at that edge.
- **Hold during EXEC**: `pc` and `inst` hold constant for the whole `EXEC` interval, however many cycles the core takes.

## Test plan
1. **Reset, zero wait**: reset with memory always ready and 1-cycle response.
   - Required: `mem_addr`=8000_0000 in cycle 2.
   - Required: `inst_valid` in cycle 4, `inst`=`mem_rdata`.
   - With `npc`=`pc`+4: `instret` increments every 3 cycles and the address sequence is 8000_0000, 8000_0004, 8000_0008.
2. **Wait states**: `mem_req_ready` held low for 3 cycles, then response delay of 4 cycles.
   - Required: `mem_addr` stable throughout.
   - Required: exactly one `inst_valid` period.
   - Required: a stray `mem_resp_valid` during `REQ` is ignored.
3. **Slow core**: `exec_done` delayed 5 cycles.
   - Required: `pc`/`inst` are unchanged for all 5 cycles.
   - Required: a jump with `npc`=8000_0100 → next `mem_addr`=8000_0100.
4. **Misaligned next-PC**: `npc`=8000_0102.
   - Required: `fault`=1, `fault_cause`=2, `instret` incremented.
   - Required: `pc` stays at the old value and `mem_req_valid` stays 0 thereafter.
5. **Bus error**: response with `mem_resp_err`=1.
   - Required: `fault`=1, `fault_cause`=1, `inst_valid` never asserted, `instret` unchanged.
6. **Reset mid-operation**: `rst` pulsed low during `RESP` and during `FAULT`.
   - Required: all outputs return to reset values immediately.
   - Required: a late response after reset is ignored.
   - Required: fetch restarts at 8000_0000.
